led_ring_monitor: RTL

- Receive-side checker for the 16-bit rotating-LED bus driven by the LED shifter.
- Samples the one-hot `led` pattern on each divided-clock tick and decodes bit position and rotation direction.
- Counts steps and wrap-arounds, flags stalls, and latches illegal patterns or jumps.
- Sits beside the shifter on the same `clk`; feeds the seven-segment/status display and the self-check logic.

---
 rtl/led_ring_monitor_pkg.sv | 24 ++
 rtl/led_onehot_enc.sv | 27 ++
 rtl/led_ring_monitor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/led_ring_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_ring_monitor_pkg                                               |
// | Shared widths, FSM states and direction codes for the LED ring.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package led_ring_monitor_pkg;

   localparam int LED_W   = 16;
   localparam int POS_W   = 4;
   localparam int CNT_W   = 8;
   localparam int STALL_W = 4;

   // Same encoding as the shifter's dir input
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/led_onehot_enc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_onehot_enc                                                     |
// | Combinational one-hot check and bit-index encoder for the LED bus. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module led_onehot_enc
   import led_ring_monitor_pkg::*;
(
   input  logic [LED_W-1:0] led,
   output logic [POS_W-1:0] idx,
   output logic             onehot_ok
);

   always_comb begin
      idx = '0;
      for (int i = 0; i < LED_W; i++) begin
         if (led[i]) begin
            idx = POS_W'(i);
         end
      end
      // Non-zero with the lowest set bit being the only one
      onehot_ok = (led != '0) && ((led & (led - 1'b1)) == '0);
   end

endmodule
`default_nettype wire

// File: rtl/led_ring_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | led_ring_monitor                                                   |
// | Tracks the rotating one-hot LED bus: position, direction, counts.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module led_ring_monitor #(
   parameter int LED_W       = led_ring_monitor_pkg::LED_W,
   parameter int STALL_LIMIT = 3,
   parameter int CNT_W       = led_ring_monitor_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_en,
   input  logic             clr,
   input  logic [LED_W-1:0] led,
   output logic [3:0]       pos,
   output logic             pos_valid,
   output logic             dir_out,
   output logic             moving,
   output logic             stalled,
   output logic [CNT_W-1:0] step_cnt,
   output logic [CNT_W-1:0] wrap_cnt,
   output logic             err_onehot,
   output logic             err_jump
);

   import led_ring_monitor_pkg::*;

   localparam logic [CNT_W-1:0]   c_cnt_one   = 1;
   localparam logic [STALL_W-1:0] c_stall_max = '1;

   state_t             r_state;
   logic [STALL_W-1:0] r_stall_cnt;

   logic [POS_W-1:0]   w_idx;
   logic               w_ok;
   logic [POS_W-1:0]   w_delta;
   logic [STALL_W-1:0] w_stall_next;
   logic [CNT_W-1:0]   w_step_base;
   logic [CNT_W-1:0]   w_wrap_base;
   logic               w_eo_base;
   logic               w_ej_base;

   led_onehot_enc u_enc (
      .led       (led),
      .idx       (w_idx),
      .onehot_ok (w_ok)
   );

   assign w_delta      = w_idx - pos;
   assign w_stall_next = (r_stall_cnt == c_stall_max) ? c_stall_max : r_stall_cnt + 1'b1;

   // Clear is applied before the sample so a same-cycle step lands on zero
   assign w_step_base = clr ? '0 : step_cnt;
   assign w_wrap_base = clr ? '0 : wrap_cnt;
   assign w_eo_base   = clr ? 1'b0 : err_onehot;
   assign w_ej_base   = clr ? 1'b0 : err_jump;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_stall_cnt <= '0;
         pos         <= '0;
         pos_valid   <= 1'b0;
         dir_out     <= DIR_RIGHT;
         moving      <= 1'b0;
         stalled     <= 1'b0;
         step_cnt    <= '0;
         wrap_cnt    <= '0;
         err_onehot  <= 1'b0;
         err_jump    <= 1'b0;
      end else begin
         step_cnt   <= w_step_base;
         wrap_cnt   <= w_wrap_base;
         err_onehot <= w_eo_base;
         err_jump   <= w_ej_base;

         if (sample_en) begin
            case (r_state)
               ST_INIT: begin
                  if (w_ok) begin
                     pos         <= w_idx;
                     pos_valid   <= 1'b1;
                     moving      <= 1'b0;
                     r_stall_cnt <= '0;
                     r_state     <= ST_TRACK;
                  end else begin
                     err_onehot <= 1'b1;
                  end
               end

               ST_TRACK: begin
                  if (!w_ok) begin
                     err_onehot  <= 1'b1;
                     pos_valid   <= 1'b0;
                     moving      <= 1'b0;
                     stalled     <= 1'b0;
                     r_stall_cnt <= '0;
                     r_state     <= ST_INIT;
                  end else if (w_delta == 4'd0) begin
                     r_stall_cnt <= w_stall_next;
                     moving      <= 1'b0;
                     stalled     <= (int'(w_stall_next) >= STALL_LIMIT);
                  end else if (w_delta == 4'd15 || w_delta == 4'd1) begin
                     pos         <= w_idx;
                     dir_out     <= (w_delta == 4'd1) ? DIR_LEFT : DIR_RIGHT;
                     moving      <= 1'b1;
                     r_stall_cnt <= '0;
                     stalled     <= 1'b0;
                     step_cnt    <= w_step_base + c_cnt_one;
                     // Crossing between index 0 and 15 in either direction
                     if ((w_delta == 4'd15 && pos == 4'd0) ||
                         (w_delta == 4'd1  && pos == 4'd15)) begin
                        wrap_cnt <= w_wrap_base + c_cnt_one;
                     end
                  end else begin
                     err_jump    <= 1'b1;
                     pos         <= w_idx;
                     moving      <= 1'b0;
                     r_stall_cnt <= '0;
                     stalled     <= 1'b0;
                  end
               end

               default: r_state <= ST_INIT;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
